// File: rtl/alu_op_sequencer_pkg.sv
// ============================================================================
// Module      : alu_op_sequencer_pkg
// Description : Opcode and FSM encodings shared by the ALU op sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_op_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_REM    = 3'd2,
        OP_AND    = 3'd3,
        OP_OR     = 3'd4,
        OP_CONCAT = 3'd5,
        OP_EQ     = 3'd6,
        OP_LT     = 3'd7
    } alu_op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Settle counter must hold SETTLE-1 and never collapse to zero width.
    function automatic int settle_cnt_w(input int settle);
        int w;
        w = $clog2(settle + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
// ============================================================================
// Module      : alu_op_sequencer_if
// Description : Request, response and ALU-side signals of the op sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_op_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [7:0]       req_a;
    logic [7:0]       req_b;
    logic             req_chain;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [2:0]       alu_c;
    logic [7:0]       alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_result;
    logic [2:0]       rsp_op;
    logic             rsp_zero;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_chain, alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_c, rsp_valid, rsp_result, rsp_op,
               rsp_zero, op_count
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_chain, alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_c, rsp_valid, rsp_result, rsp_op,
               rsp_zero, op_count
    );
endinterface

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module      : alu_op_sequencer
// Description : Issues one op at a time to a combinational ALU, waits SETTLE
//               cycles, captures the result and returns it over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    alu_op_sequencer_if.slave bus
);

    localparam int              SC_W        = settle_cnt_w(SETTLE);
    localparam logic [SC_W-1:0] SETTLE_INIT = SC_W'(SETTLE - 1);

    logic [1:0]       state_q,  state_d;
    logic [SC_W-1:0]  settle_q, settle_d;
    logic [7:0]       alu_a_q,  alu_a_d;
    logic [7:0]       alu_b_q,  alu_b_d;
    logic [2:0]       alu_c_q,  alu_c_d;
    logic [7:0]       result_q, result_d;
    logic [2:0]       op_q,     op_d;
    logic             zero_q,   zero_d;
    logic [7:0]       last_q,   last_d;
    logic [CNT_W-1:0] count_q,  count_d;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_c_d  = alu_c_q;
        result_d = result_q;
        op_d     = op_q;
        zero_d   = zero_q;
        last_d   = last_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d  = ST_EXEC;
                    alu_c_d  = bus.req_op;
                    alu_b_d  = bus.req_b;
                    alu_a_d  = bus.req_chain ? last_q : bus.req_a;
                    settle_d = SETTLE_INIT;
                end
            end
            ST_EXEC: begin
                if (settle_q == '0) begin
                    state_d  = ST_RESP;
                    result_d = bus.alu_result;
                    op_d     = alu_c_q;
                    zero_d   = (bus.alu_result == 8'h00);
                    last_d   = bus.alu_result;
                end else begin
                    settle_d = settle_q - SC_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            alu_c_q  <= 3'b000;
            result_q <= 8'h00;
            op_q     <= 3'b000;
            zero_q   <= 1'b1;
            last_q   <= 8'h00;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_c_q  <= alu_c_d;
            result_q <= result_d;
            op_q     <= op_d;
            zero_q   <= zero_d;
            last_q   <= last_d;
            count_q  <= count_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_c      = alu_c_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_op     = op_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.op_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Self-checking bench; instance 0 uses SETTLE=1/CNT_W=16,
//               instance 1 uses SETTLE=4/CNT_W=4, each behind an 8-bit ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    logic clk;
    logic rst0;
    logic rst1;
    int   checks;
    int   failures;

    alu_op_sequencer_if #(.CNT_W(16)) if0 ();
    alu_op_sequencer_if #(.CNT_W(4))  if1 ();

    alu_op_sequencer #(.SETTLE(1), .CNT_W(16)) dut0 (.clk(clk), .reset(rst0), .bus(if0.slave));
    alu_op_sequencer #(.SETTLE(4), .CNT_W(4))  dut1 (.clk(clk), .reset(rst1), .bus(if1.slave));

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] c);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return (b == 8'h00) ? a : (a % b);
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return {a[3:0], b[3:0]};
            3'd6:    return {7'b0, a == b};
            default: return {7'b0, a < b};
        endcase
    endfunction

    always_comb if0.alu_result = alu_f(if0.alu_a, if0.alu_b, if0.alu_c);
    always_comb if1.alu_result = alu_f(if1.alu_a, if1.alu_b, if1.alu_c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req_ready;
        logic        rsp_valid;
        logic [7:0]  alu_a;
        logic [7:0]  alu_b;
        logic [2:0]  alu_c;
        logic [7:0]  rsp_result;
        logic [2:0]  rsp_op;
        logic        rsp_zero;
        logic [15:0] op_count;
    } obs_t;

    // Behavioural model: last captured result and completed-handshake count.
    logic [7:0] m_last [2];
    int         m_cnt  [2];
    int         m_settle [2];
    int         m_cntw   [2];

    function automatic obs_t observe(input int s);
        obs_t o;
        if (s == 0) begin
            o.req_ready = if0.req_ready;  o.rsp_valid = if0.rsp_valid;
            o.alu_a = if0.alu_a;  o.alu_b = if0.alu_b;  o.alu_c = if0.alu_c;
            o.rsp_result = if0.rsp_result;  o.rsp_op = if0.rsp_op;
            o.rsp_zero = if0.rsp_zero;  o.op_count = if0.op_count;
        end else begin
            o.req_ready = if1.req_ready;  o.rsp_valid = if1.rsp_valid;
            o.alu_a = if1.alu_a;  o.alu_b = if1.alu_b;  o.alu_c = if1.alu_c;
            o.rsp_result = if1.rsp_result;  o.rsp_op = if1.rsp_op;
            o.rsp_zero = if1.rsp_zero;  o.op_count = 16'(if1.op_count);
        end
        return o;
    endfunction

    task automatic set_req(input int s, input logic v, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b, input logic ch);
        if (s == 0) begin
            if0.req_valid = v; if0.req_op = op; if0.req_a = a; if0.req_b = b; if0.req_chain = ch;
        end else begin
            if1.req_valid = v; if1.req_op = op; if1.req_a = a; if1.req_b = b; if1.req_chain = ch;
        end
    endtask

    task automatic set_rsp(input int s, input logic r);
        if (s == 0) if0.rsp_ready = r;
        else        if1.rsp_ready = r;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset(input int s);
        m_last[s] = 8'h00;
        m_cnt[s]  = 0;
    endtask

    // Drives one full transaction and checks issue, latency, backpressure and handshake.
    task automatic do_op(input int s, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic ch, input int hold);
        obs_t       o;
        logic [7:0] ea;
        logic [7:0] er;
        int         n;
        ea = ch ? m_last[s] : a;
        er = alu_f(ea, b, op);
        set_req(s, 1'b1, op, a, b, ch);
        set_rsp(s, (hold == 0));
        n = 0;
        o = observe(s);
        while (!o.req_ready && n < 40) begin
            cycle();
            n++;
            o = observe(s);
        end
        if (!o.req_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout inst=%0d req_ready=%b required=1", s, o.req_ready);
            set_req(s, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
            return;
        end
        cycle();
        set_req(s, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        o = observe(s);
        checks++;
        if (o.req_ready !== 1'b0 || o.alu_a !== ea || o.alu_b !== b || o.alu_c !== op) begin
            failures++;
            $display("FAIL issue inst=%0d got rdy=%b a=%h b=%h c=%0d required rdy=0 a=%h b=%h c=%0d",
                     s, o.req_ready, o.alu_a, o.alu_b, o.alu_c, ea, b, op);
        end
        for (int k = 1; k < m_settle[s]; k++) begin
            cycle();
            o = observe(s);
            checks++;
            if (o.rsp_valid !== 1'b0 || o.req_ready !== 1'b0 || o.alu_a !== ea || o.alu_c !== op) begin
                failures++;
                $display("FAIL settle inst=%0d k=%0d got vld=%b rdy=%b a=%h c=%0d required vld=0 rdy=0 a=%h c=%0d",
                         s, k, o.rsp_valid, o.req_ready, o.alu_a, o.alu_c, ea, op);
            end
        end
        cycle();
        o = observe(s);
        checks++;
        if (o.rsp_valid !== 1'b1 || o.rsp_result !== er || o.rsp_op !== op ||
            o.rsp_zero !== (er == 8'h00) || o.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL response inst=%0d got vld=%b res=%h op=%0d z=%b rdy=%b required vld=1 res=%h op=%0d z=%b rdy=0",
                     s, o.rsp_valid, o.rsp_result, o.rsp_op, o.rsp_zero, o.req_ready,
                     er, op, (er == 8'h00));
        end
        for (int k = 0; k < hold; k++) begin
            set_req(s, 1'b1, ~op, ~a, b ^ 8'h5A, 1'b0);
            cycle();
            o = observe(s);
            checks++;
            if (o.rsp_valid !== 1'b1 || o.rsp_result !== er || o.rsp_op !== op ||
                o.req_ready !== 1'b0 || o.alu_a !== ea || o.alu_c !== op) begin
                failures++;
                $display("FAIL backpressure inst=%0d k=%0d got vld=%b res=%h op=%0d rdy=%b a=%h required vld=1 res=%h op=%0d rdy=0 a=%h",
                         s, k, o.rsp_valid, o.rsp_result, o.rsp_op, o.req_ready, o.alu_a, er, op, ea);
            end
        end
        // A competing request is held through the handshake edge; it must not be taken.
        set_req(s, 1'b1, ~op, ~a, b ^ 8'h5A, 1'b0);
        set_rsp(s, 1'b1);
        cycle();
        m_last[s] = er;
        m_cnt[s]  = (m_cnt[s] + 1) % (1 << m_cntw[s]);
        o = observe(s);
        checks++;
        if (o.rsp_valid !== 1'b0 || o.req_ready !== 1'b1 || o.op_count !== 16'(m_cnt[s]) ||
            o.alu_a !== ea || o.alu_b !== b || o.alu_c !== op) begin
            failures++;
            $display("FAIL handshake inst=%0d got vld=%b rdy=%b cnt=%0d a=%h c=%0d required vld=0 rdy=1 cnt=%0d a=%h c=%0d",
                     s, o.rsp_valid, o.req_ready, o.op_count, o.alu_a, o.alu_c, m_cnt[s], ea, op);
        end
        set_req(s, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        set_rsp(s, 1'b0);
    endtask

    task automatic check_reset_vals(input int s, input string tag);
        obs_t o;
        o = observe(s);
        checks++;
        if (o.req_ready !== 1'b1 || o.rsp_valid !== 1'b0 || o.alu_a !== 8'h00 ||
            o.alu_b !== 8'h00 || o.alu_c !== 3'b000 || o.rsp_result !== 8'h00 ||
            o.rsp_op !== 3'b000 || o.rsp_zero !== 1'b1 || o.op_count !== 16'd0) begin
            failures++;
            $display("FAIL %s inst=%0d got rdy=%b vld=%b a=%h b=%h c=%0d res=%h op=%0d z=%b cnt=%0d required rdy=1 vld=0 zeros z=1",
                     tag, s, o.req_ready, o.rsp_valid, o.alu_a, o.alu_b, o.alu_c,
                     o.rsp_result, o.rsp_op, o.rsp_zero, o.op_count);
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        set_req(0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0); set_rsp(0, 1'b0);
        set_req(1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0); set_rsp(1, 1'b0);
        cycle(); cycle();
        rst0 = 1'b0; rst1 = 1'b0;
        model_reset(0); model_reset(1);
        check_reset_vals(0, "reset_init");
        check_reset_vals(1, "reset_init");
        // Park instance 0 in RESP with nonzero state, then reset between edges.
        set_req(0, 1'b1, OP_OR, 8'h5A, 8'h81, 1'b0);
        cycle();
        set_req(0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        cycle();
        #2;
        rst0 = 1'b1;
        #1;
        check_reset_vals(0, "reset_async");
        cycle();
        rst0 = 1'b0;
        model_reset(0);
        check_reset_vals(0, "reset_release");
    endtask

    task automatic test_add();
        do_op(0, OP_ADD, 8'h05, 8'h03, 1'b0, 0);
    endtask

    task automatic test_chain();
        do_op(0, OP_SUB, 8'h08, 8'h08, 1'b0, 0);
        do_op(0, OP_OR, 8'hFF, 8'hA0, 1'b1, 0);
        do_op(0, OP_ADD, 8'h11, 8'h01, 1'b1, 1);
    endtask

    task automatic test_backpressure();
        do_op(0, OP_LT, 8'h03, 8'h07, 1'b0, 5);
        do_op(1, OP_EQ, 8'h42, 8'h42, 1'b0, 3);
    endtask

    task automatic test_reset_exec();
        obs_t o;
        set_req(1, 1'b1, OP_ADD, 8'h20, 8'h22, 1'b0);
        cycle();
        set_req(1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        set_rsp(1, 1'b1);
        cycle();
        #2;
        rst1 = 1'b1;
        #1;
        check_reset_vals(1, "reset_exec");
        cycle();
        rst1 = 1'b0;
        model_reset(1);
        for (int k = 0; k < 6; k++) begin
            cycle();
            o = observe(1);
            checks++;
            if (o.rsp_valid !== 1'b0 || o.op_count !== 16'd0) begin
                failures++;
                $display("FAIL dropped_op k=%0d got vld=%b cnt=%0d required vld=0 cnt=0",
                         k, o.rsp_valid, o.op_count);
            end
        end
        set_rsp(1, 1'b0);
        do_op(1, OP_OR, 8'hEE, 8'h0C, 1'b1, 0);
    endtask

    task automatic test_count_wrap();
        int start;
        start = m_cnt[1];
        for (int i = 0; i < 16; i++) begin
            do_op(1, 3'(i % 8), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2));
        end
        checks++;
        if (16'(if1.op_count) !== 16'(start)) begin
            failures++;
            $display("FAIL count_wrap got cnt=%0d required %0d", if1.op_count, start);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op(0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_settle[0] = 1; m_cntw[0] = 16;
        m_settle[1] = 4; m_cntw[1] = 4;
        test_reset();
        test_add();
        test_chain();
        test_backpressure();
        test_reset_exec();
        test_count_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
